ps2_arrow_tracker: RTL
======================

Name: ps2_arrow_tracker

Overview:
- Sequential successor to the combinational arrow-key scancode decoder.
- Consumes a PS/2 set-2 byte stream one byte at a time and parses the E0 (extended) and F0 (break) prefixes.
- Tracks the held state of the four arrow keys and emits one-cycle press/release pulses.
- Sits between the PS/2 byte receiver and game/UI control logic.

Parameters:
- TIMEOUT_CYCLES, 1024: idle cycles allowed after a prefix byte before the parser abandons the sequence. 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- areset  input  1  asynchronous active-high reset
- byte_valid  input  1  byte_in is valid this cycle (single-cycle strobe per byte)
- byte_in  input  8  received scancode byte
- clr_all  input  1  synchronous request to release all held keys
- left  output  1  left arrow held (registered level)
- down  output  1  down arrow held
- right  output  1  right arrow held
- up  output  1  up arrow held
- press  output  4  one-cycle make pulses, bit order {up,left,down,right} = [3:0]
- release  output  4  one-cycle break pulses, same bit order
- err  output  1  one-cycle protocol error / timeout pulse

Behaviour:
- Reset (async, areset=1):
  - State IDLE; counter 0.
  - left/down/right/up=0; press=0; release=0; err=0.
- Arrow codes (after E0): 6B=left, 72=down, 74=right, 75=up.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on cycles with byte_valid=1, except timeout and clr_all.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - Other bytes -> IDLE, ignored.
  - EXT:
    - F0 -> EXT_BRK.
    - Arrow code -> make event, then IDLE.
    - E0 -> err pulse, stay EXT.
    - Other bytes -> IDLE, ignored.
  - BRK:
    - E0 or F0 -> err pulse, then IDLE.
    - Any other byte -> IDLE (non-extended break, ignored).
  - EXT_BRK:
    - Arrow code -> break event, then IDLE.
    - E0 or F0 -> err pulse, then IDLE.
    - Other bytes -> IDLE.
- Make event:
  - Key not held: set held bit and pulse press bit.
  - Key already held (typematic repeat): no pulse, held stays 1.
- Break event:
  - Key held: clear held bit and pulse release bit.
  - Key not held: no pulse.
- Latency:
  - Held level and pulses update on the clock edge that samples byte_valid.
  - They are visible the cycle after the input, and pulses last exactly one cycle.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle with byte_valid=0 and clears on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte: next state IDLE, err pulse, counter 0. Held keys are unchanged.
  - byte_valid in the same cycle as expiry: the byte is processed normally and there is no timeout.
- clr_all=1 (priority over byte_valid):
  - Every held key clears, with a release pulse for each key that was held.
  - State IDLE, counter 0; the byte in that cycle is discarded.
- Multiple keys may be held simultaneously; the outputs are independent.
- areset asserted mid-sequence: immediate return to reset values, with no pulses generated.

Optional Feature:
- Macro: PS2_KEYPAD_ARROWS_EN
- Defined:
  - Non-extended codes 6B/72/74/75 received in IDLE are treated as arrow make events.
  - The same codes received in BRK are treated as arrow break events.
  - Numeric-keypad arrows therefore alias to the arrow outputs; same typematic and pulse rules apply.
- Undefined: non-extended codes are ignored exactly as described above.

Test Plan:
- Bytes E0,75 -> press=4'b1000 for one cycle, up=1. Then E0,F0,75 -> release=4'b1000 for one cycle, up=0.
- E0,6B repeated 3 times -> single press[2] pulse, left stays 1. Then E0,F0,74 (right not held) -> no release pulse, err=0.
- E0,72 then E0,74, then clr_all=1 with a simultaneous byte -> release=4'b0011 in one cycle, all held=0, byte ignored.
- TIMEOUT_CYCLES=8: E0, then 8 idle cycles -> err pulse once, state IDLE. Following 75 alone -> no output change. Byte on the expiry cycle -> no err.
- E0,E0 -> err pulse, parser still EXT, next 6B -> press[2]. F0,E0 -> err pulse, state IDLE.
- With PS2_KEYPAD_ARROWS_EN defined: 72 -> press[1], down=1; F0,72 -> release[1]. Without the macro the same bytes give no output change.
- areset pulsed between E0 and 75 -> outputs 0, next lone 75 ignored.

Source files
------------

// File: rtl/ps2_arrow_tracker.sv
// ps2_arrow_tracker: parses a PS/2 set-2 byte stream (E0 extended / F0 break
// prefixes), tracks the held state of the four arrow keys and emits one-cycle
// press / release / error pulses.
//
// Optional feature: define PS2_KEYPAD_ARROWS_EN to alias the non-extended
// numeric-keypad codes 6B/72/74/75 onto the arrow outputs.
//
// Ports:
//   clk         system clock, all state on rising edge
//   areset      asynchronous active-high reset
//   byte_valid  single-cycle strobe qualifying byte_in
//   byte_in     received scancode byte
//   clr_all     synchronous release of every held key (priority over bytes)
//   left/down/right/up  registered held levels
//   press       one-cycle make pulses,  [3:0] = {up,left,down,right}
//   release_o   one-cycle break pulses, same order ("release" is a reserved word)
//   err         one-cycle protocol error / prefix timeout pulse
module ps2_arrow_tracker #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       clr_all,
    output logic       left,
    output logic       down,
    output logic       right,
    output logic       up,
    output logic [3:0] press,
    output logic [3:0] release_o,
    output logic       err
);

    // A zero timeout disables the counter; keep at least one bit so widths stay legal.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       held_q, held_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       rel_q, rel_d;
    logic             err_q, err_d;

    logic [3:0]       key_mask;
    logic             is_ext;
    logic             is_brk;
    logic             is_key;
    logic             do_make;
    logic             do_break;

    // Arrow code to one-hot key mask in {up,left,down,right} order.
    always_comb begin
        key_mask = 4'b0000;
        case (byte_in)
            CODE_UP:    key_mask = 4'b1000;
            CODE_LEFT:  key_mask = 4'b0100;
            CODE_DOWN:  key_mask = 4'b0010;
            CODE_RIGHT: key_mask = 4'b0001;
            default:    key_mask = 4'b0000;
        endcase
    end

    assign is_ext = (byte_in == CODE_EXT);
    assign is_brk = (byte_in == CODE_BRK);
    assign is_key = (key_mask != 4'b0000);

    // Next-state, timeout counter and event generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        press_d  = 4'b0000;
        rel_d    = 4'b0000;
        err_d    = 1'b0;
        do_make  = 1'b0;
        do_break = 1'b0;

        if (clr_all) begin
            rel_d   = held_q;
            held_d  = 4'b0000;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (byte_valid) begin
            cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (is_ext) begin
                        state_d = S_EXT;
                    end else if (is_brk) begin
                        state_d = S_BRK;
                    end else begin
`ifdef PS2_KEYPAD_ARROWS_EN
                        do_make = is_key;
`endif
                        state_d = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (is_brk) begin
                        state_d = S_EXT_BRK;
                    end else if (is_ext) begin
                        // Duplicate E0: flag it but keep waiting for the key code.
                        err_d   = 1'b1;
                        state_d = S_EXT;
                    end else begin
                        do_make = is_key;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (is_ext || is_brk) begin
                        err_d = 1'b1;
                    end else begin
`ifdef PS2_KEYPAD_ARROWS_EN
                        do_break = is_key;
`endif
                    end
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    if (is_ext || is_brk) begin
                        err_d = 1'b1;
                    end else begin
                        do_break = is_key;
                    end
                    state_d = S_IDLE;
                end
            endcase
        end else if ((state_q != S_IDLE) && (TIMEOUT_CYCLES != 0)) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Typematic repeats and breaks of un-held keys produce no pulse.
        if (do_make) begin
            press_d = key_mask & ~held_q;
            held_d  = held_q | key_mask;
        end
        if (do_break) begin
            rel_d  = key_mask & held_q;
            held_d = held_q & ~key_mask;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            held_q  <= 4'b0000;
            press_q <= 4'b0000;
            rel_q   <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            err_q   <= err_d;
        end
    end

    assign up        = held_q[3];
    assign left      = held_q[2];
    assign down      = held_q[1];
    assign right     = held_q[0];
    assign press     = press_q;
    assign release_o = rel_q;
    assign err       = err_q;

endmodule
